// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, sequencer states, ALU ops.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt,
        AluLui
    } alu_op_e;

    function automatic logic is_legal(logic [5:0] op, logic [5:0] funct);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_AND) ||
                              (funct == FN_OR) || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic alu_op_e alu_decode(logic [5:0] op, logic [5:0] funct);
        alu_op_e alu_op;
        alu_op = AluAdd;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SUBU: alu_op = AluSub;
                    FN_AND:  alu_op = AluAnd;
                    FN_OR:   alu_op = AluOr;
                    FN_SLT:  alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
            end
            OP_BEQ:  alu_op = AluSub;
            OP_ORI:  alu_op = AluOr;
            OP_LUI:  alu_op = AluLui;
            default: alu_op = AluAdd;
        endcase
        return alu_op;
    endfunction

endpackage

// File: rtl/mips_multicycle_if.sv
// Unified memory port: one request at a time, completes on the cycle mem_ready is high.
interface mips_multicycle_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 hardwired.
module mips_multicycle_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core sharing one memory port between fetch and load/store; halts on bad opcodes.
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rst,
    mips_multicycle_if.master   mem,
    output logic [ADDR_W-1:0]   PC,
    output logic                halted
);

    state_e            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       tgt_q, tgt_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, imm_zext, opb, alu_res, pc_ext, jump_pc, branch_pc;
    logic [31:0] rf_a, rf_b, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we, req, fire;
    alu_op_e     alu_op;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign alu_op   = alu_decode(op, funct);

    assign pc_ext    = 32'(pc_q);
    assign jump_pc   = {pc_ext[31:28], ir_q[25:0], 2'b00};
    assign branch_pc = pc_ext + (imm_sext << 2);

    always_comb begin
        if ((op == OP_RTYPE) || (op == OP_BEQ)) begin
            opb = b_q;
        end else if ((op == OP_ORI) || (op == OP_LUI)) begin
            opb = imm_zext;
        end else begin
            opb = imm_sext;
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAdd:  alu_res = a_q + opb;
            AluSub:  alu_res = a_q - opb;
            AluAnd:  alu_res = a_q & opb;
            AluOr:   alu_res = a_q | opb;
            AluSlt:  alu_res = {31'b0, $signed(a_q) < $signed(opb)};
            AluLui:  alu_res = {opb[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    // run_q keeps the port quiet for the cycle after reset, so a reset mid-handshake drops req.
    assign req           = run_q && ((state_q == StFetch) || (state_q == StMem));
    assign fire          = req && mem.mem_ready;
    assign mem.mem_req   = req;
    assign mem.mem_we    = (state_q == StMem) && (op == OP_SW);
    assign mem.mem_wdata = b_q;
    assign mem.mem_addr  = (state_q == StMem) ? ADDR_W'({alu_q[31:2], 2'b00})
                                               : {pc_q[ADDR_W-1:2], 2'b00};
    assign PC            = pc_q;
    assign halted        = (state_q == StHalt);

    assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        tgt_d   = tgt_q;
        rf_we   = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (fire) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d   = rf_a;
                b_d   = rf_b;
                tgt_d = branch_pc;
                if (!is_legal(op, funct)) begin
                    state_d = StHalt;
                end else if (op == OP_J) begin
                    pc_d    = ADDR_W'(jump_pc);
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_d = alu_res;
                if (op == OP_BEQ) begin
                    if (a_q == b_q) begin
                        pc_d = ADDR_W'(tgt_q);
                    end
                    state_d = StFetch;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (fire) begin
                    if (op == OP_SW) begin
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC[ADDR_W-1:0];
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            tgt_q   <= tgt_d;
        end
    end

    mips_multicycle_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (rs),
        .rdata_a_o (rf_a),
        .raddr_b_i (rt),
        .rdata_b_o (rf_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: programs run from a modelled unified memory; a scoreboard checks
// every memory handshake (address, direction, store data, cycle spacing) in issue order.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        halted;

    mips_multicycle_if #(.ADDR_W(32)) bus ();

    mips_multicycle #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem    (bus),
        .PC     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } exp_t;

    logic [31:0] mem [4096];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          rd_wait = 0;
    int          wr_wait = 0;
    int          rsp_cnt = 0;
    int          rsp_lim;
    bit          stalled = 0;
    logic [31:0] st_addr, st_wdata;
    logic        st_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input int gap);
        exp_t e;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic exp_fetch(input logic [31:0] addr, input int gap);
        push(1'b0, addr, 32'h0, gap);
    endtask

    task automatic exp_store(input logic [31:0] addr, input logic [31:0] data, input int gap);
        push(1'b1, addr, data, gap);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h0;
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] instr);
        mem[addr[13:2]] = instr;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    // Memory responder: ready after rd_wait/wr_wait stall cycles, re-armed after each handshake.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) rsp_cnt = 0;
            if (bus.mem_req) begin
                rsp_lim = bus.mem_we ? wr_wait : rd_wait;
                if (rsp_cnt >= rsp_lim) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) mem[bus.mem_addr[13:2]] = bus.mem_wdata;
                    else bus.mem_rdata = mem[bus.mem_addr[13:2]];
                end else begin
                    bus.mem_ready = 1'b0;
                    rsp_cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                rsp_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks request stability during stalls.
    always @(negedge clk) begin
        cyc++;
        if (bus.mem_req && bus.mem_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access: got addr %h we %0d expected no access",
                         bus.mem_addr, bus.mem_we);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_addr", bus.mem_addr, mon_e.addr);
                check("sb_we", 32'(bus.mem_we), 32'(mon_e.we));
                if (mon_e.we) check("sb_wdata", bus.mem_wdata, mon_e.data);
                if (mon_e.gap != 0) check("sb_gap", 32'(cyc - last_hs), 32'(mon_e.gap));
            end
            last_hs = cyc;
            stalled = 1'b0;
        end else if (bus.mem_req) begin
            if (stalled) begin
                check("stall_addr", bus.mem_addr, st_addr);
                check("stall_we", 32'(bus.mem_we), 32'(st_we));
                check("stall_wdata", bus.mem_wdata, st_wdata);
            end
            stalled  = 1'b1;
            st_addr  = bus.mem_addr;
            st_we    = bus.mem_we;
            st_wdata = bus.mem_wdata;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int found;

        // Zero-wait ALU, load/store, branch and jump program.
        clear_mem();
        put(32'h3000, 32'h3401_1234);  // ori   $1,$0,0x1234
        put(32'h3004, 32'h3C02_8000);  // lui   $2,0x8000
        put(32'h3008, 32'h0022_1821);  // addu  $3,$1,$2
        put(32'h300C, 32'h0021_0021);  // addu  $0,$1,$1
        put(32'h3010, 32'hAC03_0008);  // sw    $3,8($0)
        put(32'h3014, 32'h8C04_0008);  // lw    $4,8($0)
        put(32'h3018, 32'hAC04_000C);  // sw    $4,12($0)
        put(32'h301C, 32'hAC00_0010);  // sw    $0,16($0)
        put(32'h3020, 32'h0041_2823);  // subu  $5,$2,$1
        put(32'h3024, 32'h0041_302A);  // slt   $6,$2,$1
        put(32'h3028, 32'h0061_3824);  // and   $7,$3,$1
        put(32'h302C, 32'h2409_FFFF);  // addiu $9,$0,-1
        put(32'h3030, 32'hAC05_0014);  // sw    $5,20($0)
        put(32'h3034, 32'hAC06_0018);  // sw    $6,24($0)
        put(32'h3038, 32'hAC07_001C);  // sw    $7,28($0)
        put(32'h303C, 32'hAC09_0020);  // sw    $9,32($0)
        put(32'h3040, 32'h1022_0001);  // beq   $1,$2,+1 (not taken)
        put(32'h3044, 32'hAC01_0024);  // sw    $1,36($0)
        put(32'h3048, 32'h0800_0C40);  // j     0x3100
        put(32'h304C, 32'hAC09_0028);  // sw    $9,40($0) (skipped)
        put(32'h3100, 32'h1021_FFFF);  // beq   $1,$1,-1

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", 32'(bus.mem_req), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_pc", pc, 32'h3000);

        exp_fetch(32'h3000, 0);
        exp_fetch(32'h3004, 4);
        exp_fetch(32'h3008, 4);
        exp_fetch(32'h300C, 4);
        exp_fetch(32'h3010, 4);
        exp_store(32'h0008, 32'h8000_1234, 3);
        exp_fetch(32'h3014, 1);
        exp_fetch(32'h0008, 3);
        exp_fetch(32'h3018, 2);
        exp_store(32'h000C, 32'h8000_1234, 3);
        exp_fetch(32'h301C, 1);
        exp_store(32'h0010, 32'h0000_0000, 3);
        exp_fetch(32'h3020, 1);
        exp_fetch(32'h3024, 4);
        exp_fetch(32'h3028, 4);
        exp_fetch(32'h302C, 4);
        exp_fetch(32'h3030, 4);
        exp_store(32'h0014, 32'h7FFF_EDCC, 3);
        exp_fetch(32'h3034, 1);
        exp_store(32'h0018, 32'h0000_0001, 3);
        exp_fetch(32'h3038, 1);
        exp_store(32'h001C, 32'h0000_1234, 3);
        exp_fetch(32'h303C, 1);
        exp_store(32'h0020, 32'hFFFF_FFFF, 3);
        exp_fetch(32'h3040, 1);
        exp_fetch(32'h3044, 3);
        exp_store(32'h0024, 32'h0000_1234, 3);
        exp_fetch(32'h3048, 1);
        exp_fetch(32'h3100, 2);
        for (int i = 0; i < 3; i++) exp_fetch(32'h3100, 3);

        @(negedge clk);
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (hs_count >= 1) found = 1;
        end
        check("first_fetch_seen", 32'(found), 32'h1);
        @(posedge clk);
        #1;
        check("pc_after_fetch", pc, 32'h3004);
        drain("drain_zero_wait", 500);
        rst = 1'b1;

        // Three wait states on every access, ending on an illegal opcode.
        repeat (2) @(posedge clk);
        clear_mem();
        put(32'h3000, 32'h3401_1234);  // ori  $1,$0,0x1234
        put(32'h3004, 32'h3C02_8000);  // lui  $2,0x8000
        put(32'h3008, 32'h0022_1821);  // addu $3,$1,$2
        put(32'h300C, 32'hAC03_0008);  // sw   $3,8($0)
        put(32'h3010, 32'h8C04_0008);  // lw   $4,8($0)
        put(32'h3014, 32'hAC04_000C);  // sw   $4,12($0)
        put(32'h3018, 32'hFC00_0000);  // opcode 0x3F
        rd_wait = 3;
        wr_wait = 3;
        exp_fetch(32'h3000, 0);
        exp_fetch(32'h3004, 7);
        exp_fetch(32'h3008, 7);
        exp_fetch(32'h300C, 7);
        exp_store(32'h0008, 32'h8000_1234, 6);
        exp_fetch(32'h3010, 4);
        exp_fetch(32'h0008, 6);
        exp_fetch(32'h3014, 5);
        exp_store(32'h000C, 32'h8000_1234, 6);
        exp_fetch(32'h3018, 4);
        @(negedge clk);
        rst = 1'b0;
        drain("drain_wait_states", 500);
        @(posedge clk);
        #1;
        check("halted_in_decode", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        check("halted_set", 32'(halted), 32'h1);
        check("halt_pc", pc, 32'h301C);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req || (pc != 32'h301C) || !halted) bad++;
        end
        check("halt_absorbing", 32'(bad), 32'h0);

        // Reset while a store sits stalled in MEM.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        clear_mem();
        put(32'h3000, 32'h3401_55AA);  // ori $1,$0,0x55AA
        put(32'h3004, 32'hAC01_002C);  // sw  $1,44($0)
        rd_wait = 0;
        wr_wait = 1000;
        exp_fetch(32'h3000, 0);
        exp_fetch(32'h3004, 4);
        @(negedge clk);
        rst = 1'b0;
        drain("drain_reset_prog", 100);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req && bus.mem_we) found = 1;
        end
        check("store_stalled", 32'(found), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_drop", 32'(bus.mem_req), 32'h0);
        check("rst_pc", pc, 32'h3000);
        check("rst_halted", 32'(halted), 32'h0);
        repeat (10) @(negedge clk);
        check("no_store_commit", mem[11], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Multi-cycle MIPS core. Successor to the single-cycle core.
- One FSM-sequenced datapath replaces the separate instruction and data memories with one shared memory port using a req/ready handshake, so the core tolerates wait states.
- Reset PC and memory address width are parametrised. Illegal opcodes halt the core and raise a flag instead of executing undefined behaviour.
- Sits at CPU top level; the testbench or SoC shell attaches a unified memory.

Parameters:
- ADDR_W, 32, width of mem_addr and PC; upper bits truncated, PC arithmetic wraps mod 2^ADDR_W.
- RESET_PC, 32'h0000_3000, PC value loaded on reset (low ADDR_W bits used).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  ADDR_W  byte address, word aligned (bits[1:0]=0).
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, sampled when mem_req&&mem_ready.
- mem_ready  in  1  access completes this cycle.
- PC  out  ADDR_W  current instruction address.
- halted  out  1  core stopped on illegal opcode.

Behaviour:
- Reset: PC=RESET_PC, state=FETCH, all GPRs=0, halted=0, mem_req=0, mem_we=0, IR=0.
- Reset is honoured in any state, including mid-handshake: the request drops the next cycle and no register or memory write commits.
- ISA: R-type addu/subu/and/or/slt (funct 21,23,24,25,2A); addiu, ori, lui, lw, sw, beq, j.
- Extension: ori and lui use zero extension; all others use sign extension.
- No overflow traps. slt is a signed compare.
- $0 reads 0 and writes to it are discarded.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Stay while !mem_ready.
  - On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=rs, B<=rt.
  - Compute branch target = PC+4(already) + (sext(imm)<<2).
  - Illegal op/funct -> HALT.
  - j: PC<={PC[31:28],target,2'b00} -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - ALUOut<=ALU result.
  - beq: if A==B then PC<=target; -> FETCH.
  - lw/sw -> MEM. Others -> WB.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - Stay while !mem_ready.
  - On ready: sw -> FETCH; lw latches MDR<=mem_rdata -> WB.
- WB: write ALUOut or MDR to rd (R-type) or rt (I-type) -> FETCH.
- HALT: absorbing until rst. halted=1, mem_req=0, PC frozen.
- Latency with zero-wait memory, counted as cycles from FETCH entry to next FETCH entry: j=2, beq=3, R/I ALU=4, sw=4, lw=5. Each wait cycle adds one.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 && !mem_ready.
- Misaligned addresses: bits[1:0] forced to 0, no exception.
- Every register-file write and PC update commits only on a state transition edge, never in a stall cycle.

Decomposition:
- Package mips_pkg holds:
  - opcode/funct localparams;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU op encoding (ADD, SUB, AND, OR, SLT, LUI).
- Sub-module regfile:
  - 32x32, two async read ports, one sync write port.
  - Synchronous reset clears all entries.
  - Write to index 0 ignored.
- ALU and the sequencer stay inline in mips_multicycle.

Test Plan:
- Reset then run with zero-wait memory -> first mem_addr=32'h3000; PC=32'h3004 after first fetch completes.
- ori $1,$0,0x1234; lui $2,0x8000; addu $3,$1,$2 -> $3=32'h8000_1234 after 4+4+4 cycles. Write to $0 via addu $0,$1,$1 leaves $0=0.
- sw $3,8($0) then lw $4,8($0) with mem_ready delayed 3 cycles each access -> write seen at addr 8 with data 32'h8000_1234; $4 equals it; addresses held stable during wait.
- beq $1,$1,-1 -> PC loops on same address every 3 cycles. beq with unequal operands falls through to PC+4.
- Illegal opcode 6'h3F fetched -> halted=1 two cycles after fetch handshake; mem_req stays 0 and PC is frozen until rst.
- Assert rst while MEM stalls a sw (mem_ready=0) -> no write ever observed; next cycle mem_req=0, PC=RESET_PC, halted=0.
